// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding and the default operand width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/twos_com.sv
// Two's-complement negator: neg_val = -in_val, modulo 2^WIDTH (negating zero gives zero).
module twos_com #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] neg_val
);

    assign neg_val = ~in_val + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/seq_signed_mult.sv
// Multi-cycle signed shift-add multiplier: magnitudes in, WIDTH add/shift steps, sign re-applied.
module seq_signed_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sign_q, sign_d;
    logic [WIDTH-1:0]  mag_a_q, mag_a_d;
    logic [WIDTH-1:0]  mag_b_q, mag_b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     product_q, product_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  neg_a;
    logic [WIDTH-1:0]  neg_b;
    logic [PW-1:0]     neg_acc;
    logic [PW-1:0]     addend;

    twos_com #(.WIDTH(WIDTH)) u_neg_a   (.in_val(a_q),   .neg_val(neg_a));
    twos_com #(.WIDTH(WIDTH)) u_neg_b   (.in_val(b_q),   .neg_val(neg_b));
    twos_com #(.WIDTH(PW))    u_neg_acc (.in_val(acc_q), .neg_val(neg_acc));

    // -2^(WIDTH-1) negates to itself; read unsigned, that is exactly its magnitude.
    assign addend = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;

    // NOTE: every always_comb output is given its hold value first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                mag_a_d = a_q[WIDTH-1] ? neg_a : a_q;
                mag_b_d = b_q[WIDTH-1] ? neg_b : b_q;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + addend;
                end
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                product_d = sign_q ? neg_acc : acc_q;
                state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: reset is synchronous (checked inside the clocked block); all state uses <= so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/seq_signed_mult.md
# seq_signed_mult

Multi-cycle signed shift-add multiplier for the ALU datapath, sitting directly downstream of the two's-complement negator stage. It latches two signed WIDTH-bit operands on a start pulse and converts them to magnitudes through negator instances. It then accumulates the unsigned product over WIDTH cycles and re-applies the sign with a final negation. It presents a 2·WIDTH-bit signed product with a one-cycle done pulse, and serves as the multiply path behind the ALU operation mux.

## Interface
- WIDTH, 5, operand width in bits; must be ≥ 3.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  multiplicand, signed two's complement.
- b  in  WIDTH  multiplier, signed two's complement.
- busy  out  1  high in LOAD, RUN, FIX.
- done  out  1  one-cycle pulse, high only in DONE.
- product  out  2·WIDTH  signed result; holds until next accepted start.

## Operation
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE/DONE with start=1:
  - Register a, b, and sign = a[WIDTH-1] ^ b[WIDTH-1].
  - Go to LOAD.
- IDLE/DONE with start=0: IDLE.
- LOAD:
  - mag_a = negate(a) if a[WIDTH-1], else a; mag_b likewise. Both are unsigned WIDTH-bit.
  - Clear the 2·WIDTH-bit accumulator and cnt. Go to RUN.
- RUN, one multiplier bit per cycle, LSB first:
  - If mag_b[0], acc += mag_a << cnt.
  - mag_b >>= 1; cnt++.
  - After WIDTH RUN cycles (cnt = WIDTH-1 at the transition), go to FIX.
- FIX: product ← sign ? negate(acc) : acc, where negate is 2·WIDTH wide. Go to DONE.
- DONE: done=1 for exactly one cycle. Then IDLE, or LOAD if start=1.
- Width rules:
  - Magnitude of -2^(WIDTH-1) is the bit pattern 10…0, read as unsigned 2^(WIDTH-1). This is correct, not an overflow.
  - Maximum product magnitude is 2^(2·WIDTH-2). It always fits in 2·WIDTH signed bits, with no saturation.
  - Negating zero yields zero. A zero operand with sign=1 still gives product 0.
- start in LOAD/RUN/FIX is ignored: not queued, operands not re-sampled.
- Reset (rst_n=0 at an edge):
  - State → IDLE; product, acc, cnt, sign → 0; busy=0, done=0.
  - Reset mid-operation abandons the computation with no done pulse.

## Timing
- Reset values: busy=0, done=0, product=0.
- Let start be sampled at edge k:
  - LOAD is cycle k+1.
  - RUN spans k+2 … k+WIDTH+1.
  - FIX is k+WIDTH+2.
  - DONE is k+WIDTH+3.
- Latency: done and the valid product are visible after edge k+WIDTH+3 (8 cycles for WIDTH=5).
- product changes only at the FIX→DONE edge and at reset.
- Back-to-back: start high during DONE is accepted. Throughput is one result per WIDTH+3 cycles.
- busy rises after edge k and falls at the edge entering DONE. busy and done are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared alu_pkg:
  - State encoding constants (IDLE=0 … DONE=4, 3 bits).
  - Default WIDTH localparam.
- Sub-module: twos_com, the team's existing negator.
  - Two WIDTH-wide instances for operand magnitudes.
  - One 2·WIDTH-wide instance for result sign correction.
- Counter width: $clog2(WIDTH).
- The rest is one FSM plus datapath registers in seq_signed_mult.

## Test plan
- WIDTH=5, a=3, b=5, one start pulse → done exactly 8 cycles later, product=0x00F (15), busy high for 7 cycles.
- a=-3 (0x1D), b=5 → product=0x3F1 (-15). a=-3, b=-5 → product=0x00F.
- a=-16 (0x10), b=-16 → product=0x100 (256). a=-16, b=15 → product=0x310 (-240).
- a=0, b=-7 → product=0x000 with sign=1 internally. Afterwards a=-1, b=1 → 0x3FF.
- start re-pulsed with a=7, b=7 during RUN of 2×3 → ignored, product=0x006. Then start held high in DONE with a=7, b=7 → new op accepted, product=0x031 after another 8 cycles.
- rst_n low for 1 cycle mid-RUN → next cycle busy=0, done=0, product=0, no done pulse. Then a fresh start with a=2, b=2 gives 0x004.
